prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer-side counterpart of the byte-addressed, little-endian instruction memory.
- Accepts a byte stream through a valid/ready handshake. The stream carries a 4-byte little-endian length header followed by the payload.
- Writes payload bytes sequentially into the instruction memory's byte write port. Holds the CPU in reset while loading and pulses done at the end.
- Sits between the host byte link (UART RX or testbench) and the instruction memory write port.

Parameters:
- ADDRESS_WIDTH, 16, byte-address width of the instruction memory; depth is 2**ADDRESS_WIDTH bytes.
- DATA_WIDTH, 8, memory byte width; the stream byte is the same width.
- BASE_ADDR, 0, first byte address written; the value is truncated to ADDRESS_WIDTH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  byte write enable to the instruction memory.
- mem_addr  out  ADDRESS_WIDTH  byte write address.
- mem_wdata  out  DATA_WIDTH  byte write data.
- cpu_hold  out  1  hold the CPU in reset; high while busy.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a load completes successfully.
- err  out  1  sticky error flag; cleared by start or rst.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - in_ready, mem_we, cpu_hold, busy, done and err all go to 0.
  - mem_addr goes to BASE_ADDR; mem_wdata goes to 0; the length and byte counters go to 0.
  - rst mid-load aborts immediately. Bytes already written stay in memory, and no done pulse is issued.
- Handshake:
  - A byte transfers on a cycle where in_valid && in_ready.
  - in_ready is a registered-state decode: 1 in LEN, DATA and CHK; 0 in IDLE and DONE.
  - in_data is not sampled unless the byte transfers.
- States:
  - IDLE:
    - On start: go to LEN, clear err, clear the length register, set the byte counter to 0.
    - start in any other state is ignored.
  - LEN:
    - Accept 4 bytes. Byte k goes into length bits [8k+7:8k] (little-endian, matching the memory read byte order).
    - After the 4th byte, if length > 2**ADDRESS_WIDTH: set err and go to IDLE with no writes.
    - Else if length == 0: go to CHK when CHECKSUM enabled, otherwise DONE.
    - Else: go to DATA.
  - DATA:
    - Each accepted byte at cycle N produces mem_we=1 at cycle N+1, with mem_wdata = that byte and mem_addr = BASE_ADDR + index.
    - index counts up from 0; mem_addr is registered and wraps modulo 2**ADDRESS_WIDTH.
    - mem_we is 0 on every cycle not immediately following an accepted data byte.
    - After byte length-1 is accepted: go to CHK when enabled, otherwise DONE. The final write still occurs the next cycle.
  - DONE:
    - done=1 for exactly one cycle, then go to IDLE.
    - done coincides with the final mem_we, or follows it; it is never before it.
- Outputs:
  - cpu_hold = busy = (state != IDLE), both registered with the state.
  - Back-to-back throughput is one byte per cycle.
- Simultaneous events:
  - rst has priority over everything.
  - start asserted together with DONE is ignored; start must be re-asserted in IDLE.
- Width rules:
  - length is 32 bits unsigned; the byte counter is 33 bits so that a length of 2**ADDRESS_WIDTH cannot overflow.
  - mem_addr arithmetic is truncated to ADDRESS_WIDTH.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A CHK state follows the payload and accepts one additional byte.
  - The running XOR of all payload bytes (reset to 0 at start) is compared with it.
  - Match: go to DONE. Mismatch: set err and go to IDLE with no done pulse.
- Undefined:
  - There is no CHK state and no XOR register; the state goes directly from DATA, or zero-length LEN, to DONE.
  - err is raised only by an oversize length.

Test Plan:
- Basic load, BASE_ADDR=0: start, stream 04 00 00 00 13 05 A0 00 -> mem writes (0,13),(1,05),(2,A0),(3,00) on consecutive cycles; done pulses once; cpu_hold falls the cycle after done; the instruction memory then reads word 0x00A00513 at address 0.
- Backpressure and stalls: same stream with in_valid toggling 1-0-1 -> writes occur only after accepted bytes; addresses have no gaps; in_ready stays 1 in DATA.
- Zero and oversize length:
  - Header 00 00 00 00 -> no mem_we; done next (after the checksum byte 00 when enabled).
  - Header 01 00 01 00 with ADDRESS_WIDTH=16 -> err=1, no mem_we, return to IDLE.
- Wrap-around: BASE_ADDR=0xFFFE, length 4, bytes AA BB CC DD -> addresses FFFE, FFFF, 0000, 0001.
- Reset mid-load: assert rst after the 2nd payload byte of 8 -> the next cycle shows all outputs at reset values and no done; a new start then loads correctly.
- Checksum (PROG_LOADER_CHECKSUM_EN):
  - Payload 12 34, checksum 26 -> done=1, err=0.
  - Checksum 27 -> err=1, no done; both payload writes already performed.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus for prog_loader.
// master = host/stream side, slave = the loader itself.
interface prog_loader_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
);
    logic                     start;
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     cpu_hold;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a length-prefixed program image into the instruction memory byte port.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          DATA_WIDTH    = 8,
    parameter int unsigned BASE_ADDR     = 0
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [32:0]              MAX_LEN = 33'(1) << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] BASE    = ADDRESS_WIDTH'(BASE_ADDR);

    state_t                   state_reg;
    state_t                   state_next;
    logic [31:0]              length_reg;
    logic [32:0]              cnt_reg;
    logic                     in_ready_reg;
    logic                     mem_we_reg;
    logic [ADDRESS_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0]    mem_wdata_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     err_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    xor_reg;
`endif

    logic        accept;
    logic [31:0] len_full;
    logic [32:0] cnt_inc;
    logic        last_hdr;
    logic        oversize;

    assign accept   = bus.in_valid && in_ready_reg;
    // Full length as it will stand once the 4th header byte lands.
    assign len_full = {bus.in_data[7:0], length_reg[23:0]};
    assign cnt_inc  = cnt_reg + 33'd1;
    assign last_hdr = (cnt_reg[1:0] == 2'd3);
    assign oversize = ({1'b0, len_full} > MAX_LEN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (accept && last_hdr) begin
                    if (oversize) begin
                        state_next = S_IDLE;
                    end else if (len_full == 32'd0) begin
                        state_next = S_TAIL;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (cnt_inc == {1'b0, length_reg})) begin
                    state_next = S_TAIL;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_next = (bus.in_data == xor_reg) ? S_DONE : S_IDLE;
                end
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            length_reg    <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_reg       <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            // Status outputs are decoded from the next state so they line up with state_reg.
            in_ready_reg <= (state_next == S_LEN) || (state_next == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                            || (state_next == S_CHK)
`endif
                            ;
            busy_reg     <= (state_next != S_IDLE);
            done_reg     <= (state_next == S_DONE);
            mem_we_reg   <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        err_reg    <= 1'b0;
                        length_reg <= '0;
                        cnt_reg    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_reg    <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        length_reg[{cnt_reg[1:0], 3'b000} +: 8] <= bus.in_data[7:0];
                        if (last_hdr) begin
                            cnt_reg <= '0;
                            if (oversize) begin
                                err_reg <= 1'b1;
                            end
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we_reg    <= 1'b1;
                        mem_wdata_reg <= bus.in_data;
                        mem_addr_reg  <= BASE + cnt_reg[ADDRESS_WIDTH-1:0];
                        cnt_reg       <= cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_reg       <= xor_reg ^ bus.in_data;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept && (bus.in_data != xor_reg)) begin
                        err_reg <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.busy      = busy_reg;
    assign bus.cpu_hold  = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 0 and base 0xFFFE) share one stream.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) if0 ();
    prog_loader_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) if1 ();

    assign if1.start    = if0.start;
    assign if1.in_valid = if0.in_valid;
    assign if1.in_data  = if0.in_data;

    prog_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    prog_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(32'hFFFE)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [23:0] wq0[$];
    logic [23:0] wq1[$];
    int          wcyc0[$];
    logic [7:0]  mem0 [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (if0.mem_we) begin
            wq0.push_back({if0.mem_addr, if0.mem_wdata});
            wcyc0.push_back(cyc);
            mem0[if0.mem_addr] = if0.mem_wdata;
        end
        if (if1.mem_we) wq1.push_back({if1.mem_addr, if1.mem_wdata});
        if (if0.done) done_cnt = done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
    endtask

    // Presents a byte and returns #1 after the edge where it transferred.
    task automatic send_byte(input logic [7:0] b);
        int t;
        if0.in_valid = 1'b1;
        if0.in_data  = b;
        t = 0;
        while (!if0.in_ready && t < 20) begin
            step();
            t++;
        end
        vectors++;
        if (!if0.in_ready) begin
            miscompares++;
            $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, required 1", if0.in_ready, t);
        end
        step();
    endtask

    task automatic send_tail(input logic [7:0] x);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(x);
`else
        if (x === 8'hxx) $display("unreachable");
`endif
    endtask

    task automatic clear_log();
        wq0.delete();
        wq1.delete();
        wcyc0.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.start = 1'b0; if0.in_valid = 1'b0; if0.in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({if0.in_ready, if0.mem_we, if0.cpu_hold, if0.busy, if0.done, if0.err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {if0.in_ready, if0.mem_we, if0.cpu_hold, if0.busy, if0.done, if0.err});
        end
        vectors++;
        if (if0.mem_addr !== 16'h0000 || if1.mem_addr !== 16'hFFFE || if0.mem_wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_addr: got %h/%h data %h, required 0000/fffe data 00",
                     if0.mem_addr, if1.mem_addr, if0.mem_wdata);
        end
        rst = 1'b0;
        step();
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        logic [7:0] pay [4];
        int d0;
        pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'hA0; pay[3] = 8'h00;
        clear_log();
        d0 = done_cnt;
        do_start();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(pay[i]);
        send_tail(8'hB6);
        if0.in_valid = 1'b0;
        vectors++;
        if (if0.done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done: done=%b, required 1", if0.done);
        end
`ifndef PROG_LOADER_CHECKSUM_EN
        vectors++;
        if (if0.mem_we !== 1'b1 || if0.mem_addr !== 16'h0003) begin
            miscompares++;
            $display("FAIL basic_done_with_write: we=%b addr=%h, required 1/0003", if0.mem_we, if0.mem_addr);
        end
`endif
        step();
        vectors++;
        if (if0.done !== 1'b0 || if0.cpu_hold !== 1'b0 || if0.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: done=%b hold=%b busy=%b, required 0/0/0",
                     if0.done, if0.cpu_hold, if0.busy);
        end
        vectors++;
        if (wq0.size() != 4) begin
            miscompares++;
            $display("FAIL basic_wcount: got %0d writes, required 4", wq0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wq0[i] !== {16'(i), pay[i]}) begin
                    miscompares++;
                    $display("FAIL basic_write%0d: got %h, required %h", i, wq0[i], {16'(i), pay[i]});
                end
            end
            vectors++;
            if (wcyc0[3] - wcyc0[0] != 3) begin
                miscompares++;
                $display("FAIL basic_consecutive: span %0d cycles, required 3", wcyc0[3] - wcyc0[0]);
            end
        end
        vectors++;
        if ({mem0[3], mem0[2], mem0[1], mem0[0]} !== 32'h00A00513) begin
            miscompares++;
            $display("FAIL basic_word: got %h, required 00a00513", {mem0[3], mem0[2], mem0[1], mem0[0]});
        end
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0);
        end
        $display("basic load: 4 bytes at base 0000");
    endtask

    task automatic test_stall();
        logic [7:0] pay [4];
        pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'hA0; pay[3] = 8'h00;
        clear_log();
        do_start();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(pay[i]);
            if0.in_valid = 1'b0;
            if (i < 3) begin
                step();
                vectors++;
                if (if0.mem_we !== 1'b0 || if0.in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_bubble%0d: we=%b ready=%b, required 0/1", i, if0.mem_we, if0.in_ready);
                end
            end
        end
        send_tail(8'hB6);
        if0.in_valid = 1'b0;
        step();
        vectors++;
        if (wq0.size() != 4) begin
            miscompares++;
            $display("FAIL stall_wcount: got %0d writes, required 4", wq0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wq0[i] !== {16'(i), pay[i]}) begin
                    miscompares++;
                    $display("FAIL stall_write%0d: got %h, required %h", i, wq0[i], {16'(i), pay[i]});
                end
            end
        end
        $display("stalled load: 4 bytes with valid toggling");
    endtask

    task automatic test_zero_len();
        clear_log();
        do_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_tail(8'h00);
        if0.in_valid = 1'b0;
        vectors++;
        if (if0.done !== 1'b1 || if0.mem_we !== 1'b0 || if0.err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: done=%b we=%b err=%b, required 1/0/0", if0.done, if0.mem_we, if0.err);
        end
        step();
        vectors++;
        if (wq0.size() != 0) begin
            miscompares++;
            $display("FAIL zero_writes: got %0d writes, required 0", wq0.size());
        end
        $display("zero-length load");
    endtask

    task automatic test_oversize();
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        if0.in_valid = 1'b0;
        vectors++;
        if (if0.err !== 1'b1 || if0.busy !== 1'b0 || if0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize_err: err=%b busy=%b ready=%b, required 1/0/0", if0.err, if0.busy, if0.in_ready);
        end
        step();
        vectors++;
        if (if0.err !== 1'b1 || wq0.size() != 0 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL oversize_sticky: err=%b writes=%0d done=%0d, required 1/0/0",
                     if0.err, wq0.size(), done_cnt - d0);
        end
        // Exactly 2**16 is legal: start clears err and DATA is entered.
        do_start();
        vectors++;
        if (if0.err !== 1'b0 || if0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_clears_err: err=%b ready=%b, required 0/1", if0.err, if0.in_ready);
        end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        if0.in_valid = 1'b0;
        vectors++;
        if (if0.err !== 1'b0 || if0.busy !== 1'b1 || if0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL maxlen_accept: err=%b busy=%b ready=%b, required 0/1/1", if0.err, if0.busy, if0.in_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("oversize header rejected, max length accepted");
    endtask

    task automatic test_wrap();
        clear_log();
        do_start();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_tail(8'h00);
        if0.in_valid = 1'b0;
        step();
        vectors++;
        if (wq1.size() != 4 || wq1[0] !== 24'hFFFEAA || wq1[1] !== 24'hFFFFBB
            || wq1[2] !== 24'h0000CC || wq1[3] !== 24'h0001DD) begin
            miscompares++;
            $display("FAIL wrap_addrs: got %0d writes first %h last %h, required fffeaa..0001dd",
                     wq1.size(), (wq1.size() > 0) ? wq1[0] : 24'h0, (wq1.size() > 3) ? wq1[3] : 24'h0);
        end
        $display("wrap load: base fffe, 4 bytes");
    endtask

    task automatic test_reset_mid();
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start();
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        if0.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({if0.in_ready, if0.mem_we, if0.cpu_hold, if0.busy, if0.done, if0.err} !== 6'b0
            || if0.mem_addr !== 16'h0000 || if0.mem_wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_outputs: flags=%b addr=%h data=%h, required 000000/0000/00",
                     {if0.in_ready, if0.mem_we, if0.cpu_hold, if0.busy, if0.done, if0.err},
                     if0.mem_addr, if0.mem_wdata);
        end
        step();
        vectors++;
        if (wq0.size() != 2 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL midreset_aborted: writes=%0d done=%0d, required 2/0", wq0.size(), done_cnt - d0);
        end
        $display("reset mid-load after 2 of 8 bytes");
        test_basic();
    endtask

    task automatic test_back_to_back();
        int d0;
        clear_log();
        d0 = done_cnt;
        do_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        send_tail(8'h03);
        if0.in_valid = 1'b0;
        // start during DONE must be ignored
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        vectors++;
        if (if0.busy !== 1'b0 || if0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: busy=%b ready=%b, required 0/0", if0.busy, if0.in_ready);
        end
        do_start();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        send_tail(8'h02);
        if0.in_valid = 1'b0;
        step();
        vectors++;
        if (wq0.size() != 5 || wq0[2] !== 24'h000003 || wq0[3] !== 24'h000104 || wq0[4] !== 24'h000205) begin
            miscompares++;
            $display("FAIL b2b_writes: got %0d writes last %h, required 5 ending 000205",
                     wq0.size(), (wq0.size() > 0) ? wq0[wq0.size()-1] : 24'h0);
        end
        vectors++;
        if (done_cnt - d0 != 2) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0);
        end
        $display("back-to-back loads: 2 then 3 bytes");
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int d0;
        clear_log();
        do_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
        if0.in_valid = 1'b0;
        vectors++;
        if (if0.done !== 1'b1 || if0.err !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_good: done=%b err=%b, required 1/0", if0.done, if0.err);
        end
        step();
        clear_log();
        d0 = done_cnt;
        do_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
        if0.in_valid = 1'b0;
        vectors++;
        if (if0.err !== 1'b1 || if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_bad: err=%b busy=%b done=%b, required 1/0/0", if0.err, if0.busy, if0.done);
        end
        step();
        vectors++;
        if (wq0.size() != 2 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL chk_bad_writes: writes=%0d done=%0d, required 2/0", wq0.size(), done_cnt - d0);
        end
        $display("checksum loads: 26 accepted, 27 rejected");
    endtask
`endif

    initial begin
        rst = 1'b1;
        if0.start = 1'b0;
        if0.in_valid = 1'b0;
        if0.in_data = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_oversize();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
